serial_exec_unit: RTL and testbench

- Byte-serial execute stage sitting directly downstream of the 16×32-bit byte-phased register file.
- Owns and sequences the shared 2-bit mux_phase counter (byte 0 = LSB first).
- Consumes one rs1/rs2 byte per phase and produces the rd byte for the same phase, with a carry chain held across phases.
- Produces whole-word compare flags for branch resolution.

---
 rtl/serial_exec_pkg.sv | 32 +++
 rtl/serial_exec_unit_byte_alu_slice.sv | 36 +++
 rtl/serial_exec_unit.sv | 153 +++++++++++++++
 tb/tb_serial_exec_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_exec_pkg.sv
// Shared constants, op codes and FSM state type for the byte-serial execute stage.
// The optional SLT/SLTU write-back path is enabled by defining SERIAL_EXEC_SLT_EN.
package serial_exec_pkg;

  localparam int DATA_W     = 8;
  localparam int NUM_PHASES = 4;
  localparam int PHASE_W    = $clog2(NUM_PHASES);
  localparam int OP_W       = 4;

  localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OP_W-1:0] OP_AND   = 4'd2;
  localparam logic [OP_W-1:0] OP_OR    = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd4;
  localparam logic [OP_W-1:0] OP_PASSB = 4'd5;
  localparam logic [OP_W-1:0] OP_CMP   = 4'd6;
  localparam logic [OP_W-1:0] OP_SLT   = 4'd8;
  localparam logic [OP_W-1:0] OP_SLTU  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Ops that produce an rd byte during RUN.
  function automatic logic op_writes(input logic [OP_W-1:0] op);
    return (op <= OP_PASSB);
  endfunction

endpackage

// File: rtl/serial_exec_unit_byte_alu_slice.sv
// Combinational byte ALU: result lane plus carry-out, and an always-on
// subtract chain (a + ~b + sub_c_in) used for whole-word compares.
module byte_alu_slice
  import serial_exec_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  input  logic              c_in,
  input  logic              sub_c_in,
  output logic [DATA_W-1:0] result,
  output logic              c_out,
  output logic              sub_c_out
);

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum_w;
  logic [DATA_W:0]   sub_w;

  always_comb begin
    b_eff     = (op == OP_SUB) ? ~b : b;
    sum_w     = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, c_in};
    sub_w     = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, sub_c_in};
    c_out     = sum_w[DATA_W];
    sub_c_out = sub_w[DATA_W];
    case (op)
      OP_ADD, OP_SUB: result = sum_w[DATA_W-1:0];
      OP_AND:         result = a & b;
      OP_OR:          result = a | b;
      OP_XOR:         result = a ^ b;
      OP_PASSB:       result = b;
      default:        result = '0;
    endcase
  end

endmodule

// File: rtl/serial_exec_unit.sv
// Byte-serial execute stage: sequences mux_phase, chains carries across byte phases
// and resolves whole-word compare flags. SERIAL_EXEC_SLT_EN adds the SLT/SLTU WB pass.
//
// state | meaning
// IDLE  | waiting for start; op latched when start is seen
// RUN   | phases 0..3, one byte per cycle, carry and compare chains advance
// WB    | phases 0..3 writing the SLT/SLTU flag word (SERIAL_EXEC_SLT_EN only)
// DONE  | one-cycle completion pulse, then back to IDLE
module serial_exec_unit
  import serial_exec_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [OP_W-1:0]    op,
  output logic               busy,
  output logic               done,
  output logic [PHASE_W-1:0] mux_phase,
  input  logic [DATA_W-1:0]  rs1_dat,
  input  logic [DATA_W-1:0]  rs2_dat,
  output logic [DATA_W-1:0]  rd_dat,
  output logic               rd_we,
  output logic               flag_eq,
  output logic               flag_lt,
  output logic               flag_ltu
);

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [OP_W-1:0]    op_q;
  logic               carry_q;
  logic               sub_carry_q;
  logic               eq_acc_q;

  logic               last_phase;
  logic               first_phase;
  logic               alu_c_in;
  logic               alu_sub_c_in;
  logic [DATA_W-1:0]  alu_result;
  logic               alu_c_out;
  logic               alu_sub_c_out;
  logic               byte_eq;
  logic               in_run;
  logic               in_wb;
  logic               wb_after_run;

  assign first_phase = (phase_q == '0);
  assign last_phase  = (phase_q == PHASE_W'(NUM_PHASES - 1));
  assign in_run      = (state_q == ST_RUN);
  assign byte_eq     = (rs1_dat == rs2_dat);

`ifdef SERIAL_EXEC_SLT_EN
  assign in_wb        = (state_q == ST_WB);
  assign wb_after_run = (op_q == OP_SLT) || (op_q == OP_SLTU);
`else
  assign in_wb        = 1'b0;
  assign wb_after_run = 1'b0;
`endif

  // Phase 0 seeds the chains: SUB adds ~b + 1, the compare chain always does.
  assign alu_c_in     = first_phase ? (op_q == OP_SUB) : carry_q;
  assign alu_sub_c_in = first_phase ? 1'b1 : sub_carry_q;

  byte_alu_slice u_alu (
    .a         (rs1_dat),
    .b         (rs2_dat),
    .op        (op_q),
    .c_in      (alu_c_in),
    .sub_c_in  (alu_sub_c_in),
    .result    (alu_result),
    .c_out     (alu_c_out),
    .sub_c_out (alu_sub_c_out)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        phase_d = phase_q + PHASE_W'(1);
        if (last_phase) begin
          phase_d = '0;
          state_d = wb_after_run ? ST_WB : ST_DONE;
        end
      end
`ifdef SERIAL_EXEC_SLT_EN
      ST_WB: begin
        phase_d = phase_q + PHASE_W'(1);
        if (last_phase) begin
          phase_d = '0;
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        phase_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        phase_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      op_q        <= OP_ADD;
      carry_q     <= 1'b0;
      sub_carry_q <= 1'b0;
      eq_acc_q    <= 1'b0;
      flag_eq     <= 1'b0;
      flag_lt     <= 1'b0;
      flag_ltu    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      if (state_q == ST_IDLE && start) op_q <= op;
      if (in_run) begin
        carry_q     <= alu_c_out;
        sub_carry_q <= alu_sub_c_out;
        eq_acc_q    <= byte_eq & (first_phase | eq_acc_q);
        // Sign bytes differ: rs1's sign decides; otherwise the unsigned borrow does.
        if (last_phase) begin
          flag_eq  <= byte_eq & eq_acc_q;
          flag_ltu <= ~alu_sub_c_out;
          flag_lt  <= (rs1_dat[DATA_W-1] != rs2_dat[DATA_W-1]) ? rs1_dat[DATA_W-1]
                                                               : ~alu_sub_c_out;
        end
      end
    end
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    mux_phase = (in_run || in_wb) ? phase_q : '0;
    rd_we     = (in_run && op_writes(op_q)) || in_wb;
    rd_dat    = '0;
    if (in_run) begin
      rd_dat = alu_result;
    end else if (in_wb && first_phase) begin
      rd_dat = {{(DATA_W-1){1'b0}}, (op_q == OP_SLT) ? flag_lt : flag_ltu};
    end
  end

endmodule

// File: tb/tb_serial_exec_unit.sv
// Self-checking bench for serial_exec_unit: directed plan vectors plus randomized
// ops against a word-level reference model. Honours SERIAL_EXEC_SLT_EN.
module tb_serial_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic        busy, done, rd_we;
  logic [1:0]  mux_phase;
  logic [7:0]  rs1_dat, rs2_dat, rd_dat;
  logic        flag_eq, flag_lt, flag_ltu;
  logic [31:0] a_w = 32'd0;
  logic [31:0] b_w = 32'd0;

  int vectors = 0;
  int errors  = 0;

`ifdef SERIAL_EXEC_SLT_EN
  localparam bit SLT_EN = 1'b1;
`else
  localparam bit SLT_EN = 1'b0;
`endif

  serial_exec_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .busy      (busy),
    .done      (done),
    .mux_phase (mux_phase),
    .rs1_dat   (rs1_dat),
    .rs2_dat   (rs2_dat),
    .rd_dat    (rd_dat),
    .rd_we     (rd_we),
    .flag_eq   (flag_eq),
    .flag_lt   (flag_lt),
    .flag_ltu  (flag_ltu)
  );

  always #5 clk = ~clk;

  assign rs1_dat = a_w[{mux_phase, 3'b000} +: 8];
  assign rs2_dat = b_w[{mux_phase, 3'b000} +: 8];

  // Word-level reference: result word, per-cycle write mask, done cycle, {eq,lt,ltu}.
  task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] rd, output logic [15:0] we, output logic [15:0] bz,
                       output logic [31:0] ph, output int dcyc, output logic [2:0] flg);
    logic lt_s, lt_u;
    lt_s = $signed(a) < $signed(b);
    lt_u = a < b;
    flg  = {a == b, lt_s, lt_u};
    rd   = 32'd0;
    we   = 16'd0;
    dcyc = 5;
    case (o)
      4'd0: rd = a + b;
      4'd1: rd = a - b;
      4'd2: rd = a & b;
      4'd3: rd = a | b;
      4'd4: rd = a ^ b;
      4'd5: rd = b;
      default: rd = 32'd0;
    endcase
    if (o <= 4'd5) begin
      we = 16'h001E;
    end else if (SLT_EN && (o == 4'd8 || o == 4'd9)) begin
      rd   = {31'd0, (o == 4'd8) ? lt_s : lt_u};
      we   = 16'h01E0;
      dcyc = 9;
    end
    bz = 16'd0;
    ph = 32'd0;
    for (int c = 1; c <= dcyc; c++) bz[c] = 1'b1;
    for (int c = 1; c <= 4; c++) ph[2*c +: 2] = 2'(c - 1);
    if (dcyc == 9)
      for (int c = 5; c <= 8; c++) ph[2*c +: 2] = 2'(c - 5);
  endtask

  // Drives one operation and records what the DUT did over 12 cycles.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, output logic [31:0] rd, output logic [15:0] we,
                        output logic [15:0] bz, output logic [31:0] ph, output int dcyc,
                        output int dcnt, output logic [2:0] flg);
    @(negedge clk);
    a_w = a; b_w = b; op = o; start = 1'b1;
    rd = 32'd0; we = 16'd0; bz = 16'd0; ph = 32'd0; dcyc = 0; dcnt = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      ph[2*cyc +: 2] = mux_phase;
      bz[cyc] = busy;
      if (rd_we) begin
        rd[{mux_phase, 3'b000} +: 8] = rd_dat;
        we[cyc] = 1'b1;
      end
      if (done) begin
        dcnt++;
        dcyc  = cyc;
        start = 1'b0;
      end
    end
    flg = {flag_eq, flag_lt, flag_ltu};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    vectors++; if (rd_we !== 1'b0) begin errors++; $display("FAIL reset_rd_we got=%b want=0", rd_we); end
    vectors++; if (mux_phase !== 2'd0) begin errors++; $display("FAIL reset_phase got=%0d want=0", mux_phase); end
    vectors++;
    if ({flag_eq, flag_lt, flag_ltu} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got=%b want=000", {flag_eq, flag_lt, flag_ltu});
    end
    rst = 1'b0;
  endtask

  task automatic test_ops(input int n_random);
    logic [3:0]  o_tab [6] = '{4'd0, 4'd1, 4'd6, 4'd6, 4'd8, 4'd9};
    logic [31:0] a_tab [6] = '{32'h00FF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b_tab [6] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h1234_5678, 32'h0000_0001, 32'h0000_0001};
    logic [3:0]  o;
    logic [31:0] a, b, rd, e_rd, ph, e_ph;
    logic [15:0] we, e_we, bz, e_bz;
    logic [2:0]  flg, e_flg;
    int          dcyc, e_dcyc, dcnt;
    for (int i = 0; i < 6 + n_random; i++) begin
      if (i < 6) begin
        o = o_tab[i]; a = a_tab[i]; b = b_tab[i];
      end else begin
        o = 4'($urandom_range(0, 15));
        a = $urandom;
        case ($urandom_range(0, 3))
          0:       b = a;
          1:       b = a ^ (32'h1 << $urandom_range(0, 31));
          default: b = $urandom;
        endcase
      end
      model(o, a, b, e_rd, e_we, e_bz, e_ph, e_dcyc, e_flg);
      run_op(o, a, b, 1'b0, rd, we, bz, ph, dcyc, dcnt, flg);
      vectors++; if (rd !== e_rd) begin errors++; $display("FAIL op%0d_rd op=%0d a=%h b=%h got=%h want=%h", i, o, a, b, rd, e_rd); end
      vectors++; if (we !== e_we) begin errors++; $display("FAIL op%0d_we_mask op=%0d got=%h want=%h", i, o, we, e_we); end
      vectors++; if (bz !== e_bz) begin errors++; $display("FAIL op%0d_busy_mask op=%0d got=%h want=%h", i, o, bz, e_bz); end
      vectors++; if (ph !== e_ph) begin errors++; $display("FAIL op%0d_phase_seq op=%0d got=%h want=%h", i, o, ph, e_ph); end
      vectors++; if (dcyc !== e_dcyc || dcnt !== 1) begin errors++; $display("FAIL op%0d_done op=%0d cyc=%0d cnt=%0d want cyc=%0d cnt=1", i, o, dcyc, dcnt, e_dcyc); end
      vectors++; if (flg !== e_flg) begin errors++; $display("FAIL op%0d_flags op=%0d a=%h b=%h got=%b want=%b", i, o, a, b, flg, e_flg); end
    end
  endtask

  task automatic test_start_hold();
    logic [31:0] rd, e_rd, ph, e_ph;
    logic [15:0] we, e_we, bz, e_bz;
    logic [2:0]  flg, e_flg;
    int          dcyc, e_dcyc, dcnt;
    model(4'd0, 32'h0102_0304, 32'h10FF_00FF, e_rd, e_we, e_bz, e_ph, e_dcyc, e_flg);
    run_op(4'd0, 32'h0102_0304, 32'h10FF_00FF, 1'b1, rd, we, bz, ph, dcyc, dcnt, flg);
    vectors++; if (dcnt !== 1) begin errors++; $display("FAIL hold_done_count got=%0d want=1", dcnt); end
    vectors++; if (rd !== e_rd) begin errors++; $display("FAIL hold_rd got=%h want=%h", rd, e_rd); end
    vectors++; if (bz !== e_bz) begin errors++; $display("FAIL hold_busy_mask got=%h want=%h", bz, e_bz); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, e_rd, ph, e_ph;
    logic [15:0] we, e_we, bz, e_bz;
    logic [2:0]  flg, e_flg;
    int          dcyc, e_dcyc, dcnt, stray;
    run_op(4'd6, 32'h8000_0000, 32'h0000_0001, 1'b0, rd, we, bz, ph, dcyc, dcnt, flg);
    vectors++; if (flg !== 3'b010) begin errors++; $display("FAIL premid_flags got=%b want=010", flg); end
    @(negedge clk);
    a_w = 32'h7F7F_7F7F; b_w = 32'h0101_0101; op = 4'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (mux_phase !== 2'd2) begin errors++; $display("FAIL mid_phase got=%0d want=2", mux_phase); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || mux_phase !== 2'd0) begin errors++; $display("FAIL mid_abort busy=%b phase=%0d want 0/0", busy, mux_phase); end
    vectors++; if (rd_we !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_outputs rd_we=%b done=%b want 0/0", rd_we, done); end
    vectors++;
    if ({flag_eq, flag_lt, flag_ltu} !== 3'b000) begin
      errors++; $display("FAIL mid_flags got=%b want=000", {flag_eq, flag_lt, flag_ltu});
    end
    rst = 1'b0;
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || rd_we || busy) stray++;
    end
    vectors++; if (stray !== 0) begin errors++; $display("FAIL mid_stray_activity got=%0d want=0", stray); end
    model(4'd0, 32'hFFFF_00FF, 32'h0000_FF01, e_rd, e_we, e_bz, e_ph, e_dcyc, e_flg);
    run_op(4'd0, 32'hFFFF_00FF, 32'h0000_FF01, 1'b0, rd, we, bz, ph, dcyc, dcnt, flg);
    vectors++; if (rd !== e_rd) begin errors++; $display("FAIL post_reset_rd got=%h want=%h", rd, e_rd); end
    vectors++; if (dcyc !== e_dcyc) begin errors++; $display("FAIL post_reset_done got=%0d want=%0d", dcyc, e_dcyc); end
  endtask

  initial begin
    test_reset();
    test_ops(60);
    test_start_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
